reg_cmd_sequencer: RTL
======================

Name: reg_cmd_sequencer

Overview:
- Command-level controller for the picoComputer 4-bit general register; it drives the register's control interface (cl, ld, in, inc, dec, sr, ir, sl, il) and reads back its out value.
- Accepts one command per valid/ready handshake and expands it into a timed sequence of single-cycle control pulses.
- Signals completion with a one-cycle done pulse.
- Sits between the CPU control unit and each register instance.

Parameters:
- WIDTH, 4, register data width (in, reg_q, cmd_data).
- ARG_W, 4, repeat-count width; maximum repeat is 2**ARG_W-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  opcode: 0 NOP, 1 CLR, 2 LOAD, 3 ADD, 4 SUB, 5 SHR, 6 SHL, 7 ROR.
- cmd_arg  input  ARG_W  repeat count for ADD/SUB/SHR/SHL/ROR.
- cmd_data  input  WIDTH  LOAD value; bit 0 is the serial fill bit for SHR/SHL.
- reg_q  input  WIDTH  current register output (out).
- cl, ld, inc, dec, sr, ir, sl, il  output  1 each  register controls.
- in  output  WIDTH  register parallel load value.
- busy  output  1  command in progress (state != IDLE).
- done  output  1  one-cycle completion pulse.

Behaviour:
- FSM states: IDLE, EXEC, DONE.
- cmd_ready = (state == IDLE). busy = !cmd_ready.
- Reset (async, any state): state=IDLE, counter=0, latched op/data=0. All control outputs, in, and done are 0. cmd_ready=1, busy=0. A command in flight is abandoned; no further pulses are issued.
- Accept: at a rising edge with cmd_valid && cmd_ready, latch cmd_op, cmd_arg and cmd_data. Changes on cmd_* after acceptance are ignored.
- Pulse count N: NOP 0; CLR 1; LOAD 1; ADD/SUB/SHR/SHL/ROR cmd_arg.
- If N=0 (NOP, or any repeat op with arg 0): IDLE->DONE, no control pulses.
- Otherwise: IDLE->EXEC, counter=N.
- EXEC: each cycle, exactly one control output is 1, chosen by the latched op:
  - CLR: cl.
  - LOAD: ld, with in=latched data.
  - ADD: inc.
  - SUB: dec.
  - SHR: sr, with ir=data[0].
  - SHL: sl, with il=data[0].
  - ROR: sr, with ir=reg_q[0], sampled live each cycle so the rotation is cumulative.
- in is 0 outside LOAD. ir/il are 0 outside their shift cycles.
- The counter decrements at each EXEC edge; at counter==1 the FSM goes EXEC->DONE.
- DONE: done=1 for exactly one cycle, all controls 0, then DONE->IDLE.
- Timing: command accepted at edge k.
  - Pulses are active in cycles k+1..k+N.
  - done is active in cycle k+N+1.
  - cmd_ready returns in cycle k+N+2.
  - Back-to-back throughput: N+2 cycles per command.
- Control outputs are decoded from registered state only; they never depend combinationally on cmd_*. ROR ir is the one allowed dependence on reg_q.
- Mutual exclusion: at most one of cl, ld, inc, dec, sr, sl is high in any cycle. The register's internal priority is therefore never exercised.
- Arithmetic wrap (ADD 3 on 14 -> 1) belongs to the register; the sequencer only issues pulses.
- cmd_valid while busy: ignored and held off by cmd_ready=0; no queueing.
- cmd_valid asserted in the same cycle reset deasserts: not accepted until the first edge with rst=0.

Test Plan:
- Reset: rst=1 mid-EXEC of ADD 10 -> all controls and done drop to 0 immediately, cmd_ready=1. After release, the register shows no further inc pulses.
- LOAD 4'b1010 accepted at edge k -> ld=1 and in=1010 in cycle k+1 only, done in k+2, cmd_ready in k+3. The register reads 1010.
- ADD 3 on a register loaded with 14 -> exactly 3 consecutive inc cycles, then a done pulse; register=1. SUB 0 -> no dec pulses, done one cycle after accept.
- SHL 2 with data[0]=1 on 0011 -> two sl cycles with il=1; register=1111. SHR 1 with data[0]=0 on 1111 -> 0111.
- ROR 5 on 1001 -> five sr cycles, each with ir equal to the then-current bit 0 (1,0,0,1,1); final register=1100. A bench assertion checks one-hot controls every cycle.
- Handshake: cmd_valid held high with changing cmd_op during EXEC -> the second command is accepted only at the edge where cmd_ready=1. Random sequences of 1000 commands checked against a reference register model.

Source files
------------

// File: rtl/reg_cmd_sequencer.sv
// Command-level sequencer for the picoComputer 4-bit general register.
// Expands one accepted command into N single-cycle control pulses followed by a done pulse.
module reg_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int ARG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [ARG_W-1:0] cmd_arg,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] reg_q,
    output logic             cl,
    output logic             ld,
    output logic             inc,
    output logic             dec,
    output logic             sr,
    output logic             ir,
    output logic             sl,
    output logic             il,
    output logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_CLR  = 3'd1;
    localparam logic [2:0] OP_LOAD = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_ROR  = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state;
    logic [ARG_W-1:0] count;
    logic [ARG_W-1:0] pulse_n;
    logic             ir_fixed;
    logic             ror_active;

    always_comb begin
        pulse_n = '0;
        case (cmd_op)
            OP_NOP:          pulse_n = '0;
            OP_CLR, OP_LOAD: pulse_n = ARG_W'(1);
            default:         pulse_n = cmd_arg;
        endcase
    end

    // Pulse registers are loaded at acceptance and held for the whole EXEC run,
    // so the control outputs never see cmd_* combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            cl         <= 1'b0;
            ld         <= 1'b0;
            inc        <= 1'b0;
            dec        <= 1'b0;
            sr         <= 1'b0;
            sl         <= 1'b0;
            il         <= 1'b0;
            in         <= '0;
            ir_fixed   <= 1'b0;
            ror_active <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (pulse_n == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= EXEC;
                            count      <= pulse_n;
                            cl         <= (cmd_op == OP_CLR);
                            ld         <= (cmd_op == OP_LOAD);
                            in         <= (cmd_op == OP_LOAD) ? cmd_data : '0;
                            inc        <= (cmd_op == OP_ADD);
                            dec        <= (cmd_op == OP_SUB);
                            sr         <= (cmd_op == OP_SHR) || (cmd_op == OP_ROR);
                            ir_fixed   <= (cmd_op == OP_SHR) && cmd_data[0];
                            ror_active <= (cmd_op == OP_ROR);
                            sl         <= (cmd_op == OP_SHL);
                            il         <= (cmd_op == OP_SHL) && cmd_data[0];
                        end
                    end
                end
                EXEC: begin
                    count <= count - ARG_W'(1);
                    if (count == ARG_W'(1)) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        cl         <= 1'b0;
                        ld         <= 1'b0;
                        in         <= '0;
                        inc        <= 1'b0;
                        dec        <= 1'b0;
                        sr         <= 1'b0;
                        ir_fixed   <= 1'b0;
                        ror_active <= 1'b0;
                        sl         <= 1'b0;
                        il         <= 1'b0;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Rotation feeds the current LSB back in, so it must follow reg_q live.
    assign ir        = ir_fixed | (ror_active & reg_q[0]);
    assign cmd_ready = (state == IDLE);
    assign busy      = !cmd_ready;

endmodule
